// File: rtl/leddc_pwm_engine.sv
// Grayscale PWM engine: double-buffered SCANxCH frame memory driving CH PWM outputs,
// one scanline per Vsync window, with conventional or scrambled (segmented) PWM.
module leddc_pwm_engine #(
    parameter int unsigned CH    = 16,
    parameter int unsigned GS_W  = 16,
    parameter int unsigned SCAN  = 32,
    parameter int unsigned SEG_W = 4,
    localparam int unsigned LW   = (SCAN > 1) ? $clog2(SCAN) : 1,
    localparam int unsigned CW   = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic            GCK,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [LW-1:0]   wr_line,
    input  logic [CW-1:0]   wr_ch,
    input  logic [GS_W-1:0] wr_data,
    input  logic            swap,
    input  logic            Vsync,
    input  logic            mode,
    output logic [CH-1:0]   OUT,
    output logic [LW-1:0]   line_idx,
    output logic            line_done,
    output logic            bank_sel
);

    localparam int unsigned    Q_W       = GS_W - SEG_W;
    localparam logic [GS_W:0]  CNT_ONE   = {{GS_W{1'b0}}, 1'b1};
    localparam logic [LW-1:0]  LINE_LAST = LW'(SCAN - 1);
    localparam logic [LW-1:0]  LINE_ONE  = {{(LW-1){1'b0}}, 1'b1};

    logic [GS_W-1:0] mem [2][SCAN][CH];

    logic [GS_W:0]   cnt_q,       cnt_d;
    logic [CH-1:0]   out_q,       out_d;
    logic [LW-1:0]   line_idx_q,  line_idx_d;
    logic            line_done_q, line_done_d;
    logic            bank_sel_q,  bank_sel_d;
    logic            swap_pend_q, swap_pend_d;
    logic            mode_q,      mode_d;
    logic            vsync_dly_q, vsync_dly_d;

    logic [SEG_W-1:0] seg;
    logic [Q_W-1:0]   q;
    logic [CH-1:0]    on;

    // Only the back bank is ever written; the front bank stays stable for display.
    always_ff @(posedge GCK) begin
        if (wr_en) begin
            mem[~bank_sel_q][wr_line][wr_ch] <= wr_data;
        end
    end

    always_comb begin
        seg = cnt_q[GS_W-1:Q_W];
        q   = cnt_q[Q_W-1:0];
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [GS_W-1:0] g;
        logic            on_c;

        // Scrambled mode spreads g over 2^SEG_W segments: g_hi cycles in every
        // segment plus one extra cycle in the first g_lo segments.
        always_comb begin
            g = mem[bank_sel_q][line_idx_q][c];
            if (mode_q) begin
                on_c = (q < g[GS_W-1:SEG_W]) ||
                       ((q == g[GS_W-1:SEG_W]) && (seg < g[SEG_W-1:0]));
            end else begin
                on_c = (cnt_q < {1'b0, g});
            end
        end

        assign on[c] = on_c;
    end

    always_comb begin
        cnt_d       = cnt_q;
        out_d       = '0;
        line_idx_d  = line_idx_q;
        line_done_d = 1'b0;
        bank_sel_d  = bank_sel_q;
        swap_pend_d = swap_pend_q | swap;
        mode_d      = mode_q;
        vsync_dly_d = Vsync;

        if (!Vsync) begin
            cnt_d  = '0;
            mode_d = mode;
            if (vsync_dly_q) begin
                line_idx_d  = (line_idx_q == LINE_LAST) ? '0 : line_idx_q + LINE_ONE;
                line_done_d = 1'b1;
            end else if ((line_idx_q == '0) && (swap_pend_q || swap)) begin
                // Exchange only between frames, once line 0 is idle again.
                bank_sel_d  = ~bank_sel_q;
                swap_pend_d = 1'b0;
            end
        end else if (!cnt_q[GS_W]) begin
            out_d = on;
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge GCK) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            out_q       <= '0;
            line_idx_q  <= '0;
            line_done_q <= 1'b0;
            bank_sel_q  <= 1'b0;
            swap_pend_q <= 1'b0;
            mode_q      <= 1'b0;
            vsync_dly_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            line_idx_q  <= line_idx_d;
            line_done_q <= line_done_d;
            bank_sel_q  <= bank_sel_d;
            swap_pend_q <= swap_pend_d;
            mode_q      <= mode_d;
            vsync_dly_q <= vsync_dly_d;
        end
    end

    always_comb begin
        OUT       = out_q;
        line_idx  = line_idx_q;
        line_done = line_done_q;
        bank_sel  = bank_sel_q;
    end

endmodule

// File: tb/tb_leddc_pwm_engine.sv
// Directed bench for leddc_pwm_engine using a reduced geometry (4 ch, 8-bit GS, 8 lines)
// so whole lines and frames fit in a short run.
module tb_leddc_pwm_engine;

    localparam int unsigned CH    = 4;
    localparam int unsigned GS_W  = 8;
    localparam int unsigned SCAN  = 8;
    localparam int unsigned SEG_W = 4;
    localparam int          FULL  = (1 << GS_W) + 1;

    logic       GCK = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_line = '0;
    logic [1:0] wr_ch = '0;
    logic [7:0] wr_data = '0;
    logic       swap = 1'b0;
    logic       Vsync = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] OUT;
    logic [2:0] line_idx;
    logic       line_done;
    logic       bank_sel;

    int   total = 0;
    int   bad = 0;
    int   ld_seen = 0;
    int   on_cnt [4];
    logic [3:0] hist [0:299];
    logic exp_bank = 1'b0;

    typedef struct packed {
        logic            mode;
        logic [3:0][7:0] g;
        logic [3:0][8:0] e;
    } vec_t;

    vec_t vecs [4];

    leddc_pwm_engine #(
        .CH   (CH),
        .GS_W (GS_W),
        .SCAN (SCAN),
        .SEG_W(SEG_W)
    ) dut (
        .GCK      (GCK),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_line  (wr_line),
        .wr_ch    (wr_ch),
        .wr_data  (wr_data),
        .swap     (swap),
        .Vsync    (Vsync),
        .mode     (mode),
        .OUT      (OUT),
        .line_idx (line_idx),
        .line_done(line_done),
        .bank_sel (bank_sel)
    );

    always #5 GCK = ~GCK;

    task automatic tick;
        @(posedge GCK);
        #1;
        if (line_done) ld_seen++;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wr(input int l, input int c, input int d);
        wr_en   = 1'b1;
        wr_line = 3'(l);
        wr_ch   = 2'(c);
        wr_data = 8'(d);
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic do_swap;
        swap = 1'b1;
        tick();
        swap = 1'b0;
        exp_bank = ~exp_bank;
    endtask

    // Vsync high for n edges; optional mode toggle / back-bank write at given edge.
    task automatic run_line(input int n, input int tog_at, input int wr_at);
        for (int c = 0; c < 4; c++) on_cnt[c] = 0;
        Vsync = 1'b1;
        for (int k = 0; k < n; k++) begin
            if (k == tog_at) mode = ~mode;
            if (k == wr_at) begin
                wr_en = 1'b1; wr_line = 3'd0; wr_ch = 2'd2; wr_data = 8'hF0;
            end else begin
                wr_en = 1'b0;
            end
            tick();
            hist[k] = OUT;
            for (int c = 0; c < 4; c++) on_cnt[c] += int'(OUT[c]);
        end
        wr_en = 1'b0;
    endtask

    task automatic end_line;
        Vsync = 1'b0;
        tick();
    endtask

    task automatic goto_line0;
        Vsync = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 2 * SCAN && line_idx != 3'd0; i++) begin
            Vsync = 1'b1;
            tick();
            Vsync = 1'b0;
            tick();
            tick();
        end
        chk("goto_line0", int'(line_idx), 0);
    endtask

    initial begin
        int mism;
        bit e;

        vecs[0] = '{1'b0, {8'hFF, 8'h80, 8'h01, 8'h00}, {9'd255, 9'd128, 9'd1, 9'd0}};
        vecs[1] = '{1'b1, {8'h01, 8'hFF, 8'h80, 8'h13}, {9'd1, 9'd255, 9'd128, 9'd19}};
        vecs[2] = '{1'b0, {8'h00, 8'h10, 8'h7F, 8'h40}, {9'd0, 9'd16, 9'd127, 9'd64}};
        vecs[3] = '{1'b1, {8'hF0, 8'h0F, 8'h10, 8'h00}, {9'd240, 9'd15, 9'd16, 9'd0}};

        // Reset held with Vsync high
        rst_n = 1'b0;
        Vsync = 1'b1;
        repeat (3) tick();
        chk("rst_out", int'(OUT), 0);
        chk("rst_line_idx", int'(line_idx), 0);
        chk("rst_bank_sel", int'(bank_sel), 0);
        chk("rst_line_done", int'(line_done), 0);
        Vsync = 1'b0;
        rst_n = 1'b1;
        tick();

        // Clear both banks
        for (int b = 0; b < 2; b++) begin
            for (int l = 0; l < SCAN; l++)
                for (int c = 0; c < CH; c++) wr(l, c, 0);
            do_swap();
        end
        chk("init_bank_sel", int'(bank_sel), int'(exp_bank));

        // Table-driven full-line on-counts
        for (int v = 0; v < 4; v++) begin
            goto_line0();
            mode = vecs[v].mode;
            tick();
            for (int c = 0; c < CH; c++) wr(0, c, int'(vecs[v].g[c]));
            do_swap();
            chk($sformatf("vec%0d_bank_sel", v), int'(bank_sel), int'(exp_bank));
            ld_seen = 0;
            run_line(FULL, -1, -1);
            end_line();
            for (int c = 0; c < CH; c++)
                chk($sformatf("vec%0d_on_ch%0d", v, c), on_cnt[c], int'(vecs[v].e[c]));
            chk($sformatf("vec%0d_line_done_pulses", v), ld_seen, 1);
            chk($sformatf("vec%0d_line_idx", v), int'(line_idx), 1);
            if (v == 0) begin
                chk("m0_ch1_edge0", int'(hist[0][1]), 1);
                chk("m0_ch1_edge1", int'(hist[1][1]), 0);
                chk("m0_ch2_edge127", int'(hist[127][2]), 1);
                chk("m0_ch2_edge128", int'(hist[128][2]), 0);
                chk("m0_ch3_edge254", int'(hist[254][3]), 1);
                chk("m0_ch3_edge255", int'(hist[255][3]), 0);
                chk("m0_saturated", int'(hist[256]), 0);
            end
        end

        // Scrambled pattern, mode toggled mid-line takes effect next line
        goto_line0();
        mode = 1'b1;
        tick();
        for (int c = 0; c < CH; c++) begin
            wr(0, c, (c == 0) ? 8'h13 : 8'h00);
            wr(1, c, (c == 0) ? 8'h13 : 8'h00);
        end
        do_swap();
        run_line(FULL, 50, -1);
        mism = 0;
        for (int k = 0; k < FULL; k++) begin
            e = (k < 256) && (((k % 16) == 0) || (((k % 16) == 1) && ((k / 16) < 3)));
            if (hist[k][0] != e) mism++;
        end
        chk("m1_pattern_mismatches", mism, 0);
        chk("m1_total_on", on_cnt[0], 19);
        end_line();
        tick();
        run_line(FULL, -1, -1);
        mism = 0;
        for (int k = 0; k < FULL; k++) begin
            e = (k < 19);
            if (hist[k][0] != e) mism++;
        end
        chk("m1_next_line_conv_mismatches", mism, 0);
        end_line();

        // Swap requested at line 5 is deferred to the frame boundary
        goto_line0();
        wr(0, 0, 5);
        for (int c = 1; c < CH; c++) wr(0, c, 0);
        mism = 0;
        for (int l = 0; l < SCAN; l++) begin
            Vsync = 1'b1;
            swap = (l == 5);
            tick();
            swap = 1'b0;
            tick();
            tick();
            Vsync = 1'b0;
            tick();
            if (l < SCAN - 1) begin
                tick();
                if (bank_sel != exp_bank) mism++;
            end
        end
        chk("defer_hold_mismatches", mism, 0);
        chk("defer_F_bank_sel", int'(bank_sel), int'(exp_bank));
        chk("defer_F_line_idx", int'(line_idx), 0);
        tick();
        exp_bank = ~exp_bank;
        chk("defer_F1_bank_sel", int'(bank_sel), int'(exp_bank));
        do_swap();
        chk("idle_swap_a", int'(bank_sel), int'(exp_bank));
        do_swap();
        chk("idle_swap_b", int'(bank_sel), int'(exp_bank));
        run_line(10, -1, -1);
        chk("defer_new_data_on", on_cnt[0], 5);
        end_line();

        // Write and swap in the same idle cycle; write during display is invisible
        goto_line0();
        wr_en = 1'b1; wr_line = 3'd0; wr_ch = 2'd2; wr_data = 8'h21;
        swap = 1'b1;
        tick();
        wr_en = 1'b0;
        swap = 1'b0;
        exp_bank = ~exp_bank;
        chk("collide_bank_sel", int'(bank_sel), int'(exp_bank));
        run_line(FULL, -1, 30);
        chk("collide_on_ch2", on_cnt[2], 33);
        end_line();

        // Truncated line
        goto_line0();
        wr(0, 0, 200);
        wr(1, 0, 200);
        do_swap();
        wr(0, 0, 200);
        wr(1, 0, 200);
        ld_seen = 0;
        run_line(100, -1, -1);
        chk("trunc_on", on_cnt[0], 100);
        Vsync = 1'b0;
        tick();
        chk("trunc_F_out", int'(OUT), 0);
        chk("trunc_F_line_idx", int'(line_idx), 1);
        chk("trunc_F_line_done", int'(line_done), 1);
        tick();
        chk("trunc_F1_line_done", int'(line_done), 0);
        tick();
        tick();
        chk("trunc_line_done_pulses", ld_seen, 1);

        // Reset in the middle of line 1
        run_line(10, -1, -1);
        chk("midrst_pre_out", int'(OUT[0]), 1);
        rst_n = 1'b0;
        tick();
        chk("midrst_out", int'(OUT), 0);
        chk("midrst_line_idx", int'(line_idx), 0);
        chk("midrst_bank_sel", int'(bank_sel), 0);
        chk("midrst_line_done", int'(line_done), 0);
        rst_n = 1'b1;
        exp_bank = 1'b0;
        run_line(10, -1, -1);
        chk("post_rst_first_edge", int'(hist[0][0]), 1);
        chk("post_rst_on", on_cnt[0], 10);
        end_line();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/leddc_pwm_engine.md
# leddc_pwm_engine

Parametrised grayscale PWM engine for the LED display controller: CH channels, GS_W-bit grayscale, SCAN scanlines, double-buffered frame memory, and a selectable conventional or scrambled PWM mode. Sits behind the serial data-capture front end, which writes grayscale words into the back buffer. Drives the LED column outputs once per scanline, timed by the Vsync window on GCK.

## Interface
Parameters:
- CH, 16, number of PWM channels (OUT width)
- GS_W, 16, grayscale width; one scanline is 2^GS_W GCK cycles
- SCAN, 32, scanlines per frame
- SEG_W, 4, log2 of the scrambled-mode segment count; must satisfy 1 <= SEG_W < GS_W

Ports:
- GCK  in  1  grayscale clock, the only clock; all logic on its rising edge
- rst_n  in  1  synchronous, active-low reset
- wr_en  in  1  write strobe into the back buffer
- wr_line  in  clog2(SCAN)  scanline address of the write
- wr_ch  in  clog2(CH)  channel address of the write
- wr_data  in  GS_W  grayscale value
- swap  in  1  one-cycle request to exchange front and back buffers
- Vsync  in  1  scanline display window; high = display active
- mode  in  1  0 = conventional PWM, 1 = scrambled PWM
- OUT  out  CH  PWM outputs, registered
- line_idx  out  clog2(SCAN)  scanline currently or next displayed
- line_done  out  1  one-cycle pulse at the end of each scanline
- bank_sel  out  1  front (display) bank index; the back bank is ~bank_sel

## Operation
- Memory: two banks of SCAN×CH words, each GS_W bits wide. Banks are not reset.
- wr_en writes mem[~bank_sel][wr_line][wr_ch]. The front bank is never written.
- Counter cnt: GS_W+1 bits.
  - Vsync=0: cnt<=0, OUT<=0, mode_q<=mode.
  - Vsync=1 and cnt<2^GS_W: OUT[c]<=on(c), then cnt<=cnt+1.
  - Vsync=1 and cnt==2^GS_W: OUT<=0 and cnt holds (line saturated).
- Grayscale: g = mem[bank_sel][line_idx][c].
- Mode 0: on(c) = (cnt < g).
- Mode 1: seg = cnt[GS_W-1:GS_W-SEG_W], q = cnt[GS_W-SEG_W-1:0], g_hi = g>>SEG_W, g_lo = g[SEG_W-1:0].
  - on(c) = (q < g_hi) or (q == g_hi and seg < g_lo).
  - Total on-cycles = g in both modes.
- Mode is mode_q, sampled on the last Vsync-low edge. A mode change while Vsync is high has no effect on the current line.
- Line advance: an edge where Vsync=0 and Vsync_d=1 does:
  - line_idx <= (line_idx==SCAN-1) ? 0 : line_idx+1
  - line_done <= 1 for exactly one cycle
  - A truncated line (Vsync falls before 2^GS_W cycles) still advances.
- Swap:
  - swap sets swap_pend.
  - The swap is applied on an edge where Vsync=0, Vsync_d=0, line_idx==0 and (swap_pend or swap): bank_sel toggles and swap_pend clears.
  - A swap requested mid-frame is deferred until after line SCAN-1 ends.
  - A swap requested while the engine is idle at line 0 applies on the next edge.
- wr_en and swap in the same cycle: the write lands in the pre-swap back bank.
- Reset values: OUT=0, cnt=0, line_idx=0, line_done=0, bank_sel=0, swap_pend=0, mode_q=0, Vsync_d=0.
- Reset mid-line: all of the above return to reset values on that edge; memory contents are kept.

## Timing
- First edge with Vsync=1 evaluates cnt=0. OUT reflects on(c) for cnt=k after edge k (one-cycle latency).
- With Vsync held high ≥ 2^GS_W+1 edges, OUT[c] is high for exactly g edge-intervals.
- Vsync falling at edge F:
  - OUT=0, line_idx updated and line_done=1 after F.
  - line_done=0 after F+1.
  - The earliest swap is after F+1 (requires line_idx==0 and Vsync still low).
- line_idx changes only at Vsync falling edges or on reset, so g is stable for a whole line.
- Back-bank writes are visible only after a swap. A write to the front bank's address space during display never alters OUT.

## Test plan
- Reset: hold rst_n=0 for 3 edges with Vsync=1 → OUT=0, line_idx=0, bank_sel=0, line_done=0. Release → counting starts at cnt=0 on the next Vsync-high edge.
- Mode 0: write line 0 ch0..3 = 0x0000, 0x0001, 0x8000, 0xFFFF; swap; Vsync high for 65537 edges.
  - On-counts are 0, 1, 32768, 65535.
  - ch3 is low only on the final cycle; ch1 is high only after edge 0.
- Mode 1 (SEG_W=4): g=0x0013 (g_hi=1, g_lo=3).
  - Total on = 19.
  - Segments 0–2 are high for q=0,1; segments 3–15 are high for q=0 only.
  - Toggling mode mid-line changes nothing until the next line.
- Swap deferral: swap pulse at line_idx=5.
  - bank_sel stays 0 through line 31.
  - bank_sel toggles at F+1 after line 31 falls.
  - Line 0 of the next frame shows the new data.
  - A second swap while idle at line 0 toggles bank_sel on the next edge.
- Write/swap collision: wr_en with swap in the same idle cycle → the data appears in the displayed bank after the swap. Writes during Vsync high leave OUT unchanged.
- Truncation and reset:
  - g=200, Vsync high for 100 edges → 100 on-cycles, line_idx 0→1, one line_done pulse.
  - rst_n=0 mid-line → OUT=0 and line_idx=0 after that edge.
